// File: rtl/except_ctrl_pkg.sv
// except_ctrl_pkg: shared definitions for the MEM-stage exception sequencer.
//   - bit_* : positions of the cause flags inside mem_excepttype
//   - EXC_* : 5-bit Cause.ExcCode values
//   - state_t : sequencer FSM encoding
//   - epc_of(): EPC value for an instruction, backing up over a branch delay slot
package except_ctrl_pkg;

    // Cause flags accumulated along IF..MEM. Interrupts are not carried
    // here; they come from int_pending at the commit point.
    localparam int bit_adel_if = 0;   // fetch address error
    localparam int bit_ri      = 1;   // reserved instruction
    localparam int bit_ov      = 2;   // arithmetic overflow (EX)
    localparam int bit_tr      = 3;   // trap (EX)
    localparam int bit_sys     = 4;   // syscall
    localparam int bit_bp      = 5;   // break
    localparam int bit_adel_d  = 6;   // load address error
    localparam int bit_ades    = 7;   // store address error
    localparam int NUM_CAUSE_BITS = 8;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_DRAIN,
        S_COMMIT,
        S_REDIRECT
    } state_t;

    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/except_prio.sv
// except_prio: combinational cause priority encoder.
//   excepttype : accumulated cause flags (bit_* positions)
//   int_ok     : interrupt is pending and enabled (IE=1, EXL=0)
//   eret       : instruction is ERET
//   hit        : something must be sequenced
//   exccode    : ExcCode of the winning cause (0 when only ERET)
//   is_addr    : winner is an address error (BadVAddr must be written)
//   is_eret    : ERET wins (no cause present)
module except_prio
    import except_ctrl_pkg::*;
(
    input  logic [31:0] excepttype,
    input  logic        int_ok,
    input  logic        eret,
    output logic        hit,
    output logic [4:0]  exccode,
    output logic        is_addr,
    output logic        is_eret
);

    logic unused_excepttype;
    assign unused_excepttype = ^excepttype[31:NUM_CAUSE_BITS];

    always_comb begin
        hit     = 1'b1;
        exccode = EXC_INT;
        is_addr = 1'b0;
        is_eret = 1'b0;
        if (int_ok) begin
            exccode = EXC_INT;
        end else if (excepttype[bit_adel_if]) begin
            exccode = EXC_ADEL;
            is_addr = 1'b1;
        end else if (excepttype[bit_ri]) begin
            exccode = EXC_RI;
        end else if (excepttype[bit_ov]) begin
            exccode = EXC_OV;
        end else if (excepttype[bit_tr]) begin
            exccode = EXC_TR;
        end else if (excepttype[bit_sys]) begin
            exccode = EXC_SYS;
        end else if (excepttype[bit_bp]) begin
            exccode = EXC_BP;
        end else if (excepttype[bit_adel_d]) begin
            exccode = EXC_ADEL;
            is_addr = 1'b1;
        end else if (excepttype[bit_ades]) begin
            exccode = EXC_ADES;
            is_addr = 1'b1;
        end else if (eret) begin
            is_eret = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: commit-point exception / ERET sequencer at the MEM stage.
// Picks the winning cause, flushes the pipe, waits for data memory to go
// idle, issues one CP0 update, then holds a PC redirect until fetch takes it.
//   inputs : clk, resetn, mem_valid, mem_excepttype, mem_eret, mem_pc,
//            mem_in_delay, mem_badvaddr, int_pending, cp0_status_ie,
//            cp0_status_exl, cp0_epc, mem_busy, redirect_ready
//   outputs: flush, busy, cp0_exc_we, cp0_exccode, cp0_bd, cp0_epc_o,
//            cp0_badvaddr_we, cp0_badvaddr, cp0_exl_clr,
//            redirect_valid, redirect_pc
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_excepttype,
    input  logic        mem_eret,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay,
    input  logic [31:0] mem_badvaddr,
    input  logic        int_pending,
    input  logic        cp0_status_ie,
    input  logic        cp0_status_exl,
    input  logic [31:0] cp0_epc,
    input  logic        mem_busy,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        busy,
    output logic        cp0_exc_we,
    output logic [4:0]  cp0_exccode,
    output logic        cp0_bd,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_badvaddr_we,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_exl_clr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic        hit, is_addr, is_eret, int_ok, trigger;
    logic [4:0]  exccode;

    // Captured at trigger; held until the sequence returns to IDLE.
    logic [4:0]  exccode_q;
    logic        bd_q, is_addr_q, is_eret_q, exl_q;
    logic [31:0] epc_q, badvaddr_q, redirect_pc_q;

    assign int_ok = int_pending & cp0_status_ie & ~cp0_status_exl;

    except_prio u_prio (
        .excepttype (mem_excepttype),
        .int_ok     (int_ok),
        .eret       (mem_eret),
        .hit        (hit),
        .exccode    (exccode),
        .is_addr    (is_addr),
        .is_eret    (is_eret)
    );

    assign trigger = (state == S_IDLE) && mem_valid && hit;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (trigger) state_n = S_FLUSH;
            // Skip DRAIN when memory is already quiet so the redirect
            // appears FLUSH_CYCLES+2 cycles after the trigger.
            S_FLUSH:    if (cnt == 4'd0) state_n = mem_busy ? S_DRAIN : S_COMMIT;
            S_DRAIN:    if (!mem_busy) state_n = S_COMMIT;
            S_COMMIT:   state_n = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            exccode_q     <= 5'd0;
            bd_q          <= 1'b0;
            is_addr_q     <= 1'b0;
            is_eret_q     <= 1'b0;
            exl_q         <= 1'b0;
            epc_q         <= 32'd0;
            badvaddr_q    <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            state <= state_n;
            if (trigger) begin
                cnt        <= 4'(FLUSH_CYCLES - 1);
                exccode_q  <= exccode;
                bd_q       <= mem_in_delay;
                is_addr_q  <= is_addr;
                is_eret_q  <= is_eret;
                exl_q      <= cp0_status_exl;
                epc_q      <= epc_of(mem_pc, mem_in_delay);
                badvaddr_q <= mem_badvaddr;
            end else if (state == S_FLUSH && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // ERET target is EPC as seen in COMMIT, after any earlier mtc0 settled.
            if (state == S_COMMIT)
                redirect_pc_q <= is_eret_q ? cp0_epc : EXC_VECTOR;
        end
    end

    // A nested exception (EXL already set) still redirects but leaves CP0 alone.
    assign cp0_exc_we      = (state == S_COMMIT) && !is_eret_q && !exl_q;
    assign cp0_badvaddr_we = cp0_exc_we && is_addr_q;
    assign cp0_exl_clr     = (state == S_COMMIT) && is_eret_q;
    assign flush           = (state == S_FLUSH);
    assign busy            = (state != S_IDLE);
    assign redirect_valid  = (state == S_REDIRECT);
    assign redirect_pc     = redirect_pc_q;
    assign cp0_exccode     = exccode_q;
    assign cp0_bd          = bd_q;
    assign cp0_epc_o       = epc_q;
    assign cp0_badvaddr    = badvaddr_q;

endmodule

// File: tb/tb_except_ctrl.sv
module tb_except_ctrl;
    import except_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_eret, mem_in_delay, int_pending;
    logic        cp0_status_ie, cp0_status_exl, mem_busy, redirect_ready;
    logic [31:0] mem_excepttype, mem_pc, mem_badvaddr, cp0_epc;
    logic        flush, busy, cp0_exc_we, cp0_bd, cp0_badvaddr_we, cp0_exl_clr, redirect_valid;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc_o, cp0_badvaddr, redirect_pc;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    except_ctrl #(.EXC_VECTOR(32'hBFC0_0380), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_excepttype(mem_excepttype),
        .mem_eret(mem_eret), .mem_pc(mem_pc), .mem_in_delay(mem_in_delay),
        .mem_badvaddr(mem_badvaddr), .int_pending(int_pending), .cp0_status_ie(cp0_status_ie),
        .cp0_status_exl(cp0_status_exl), .cp0_epc(cp0_epc), .mem_busy(mem_busy),
        .redirect_ready(redirect_ready), .flush(flush), .busy(busy), .cp0_exc_we(cp0_exc_we),
        .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd), .cp0_epc_o(cp0_epc_o),
        .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
        .cp0_exl_clr(cp0_exl_clr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_instr();
        mem_valid      = 1'b0;
        mem_excepttype = 32'd0;
        mem_eret       = 1'b0;
        int_pending    = 1'b0;
        mem_pc         = 32'hDEAD_BEEF;
        mem_in_delay   = 1'b0;
        mem_badvaddr   = 32'hFFFF_FFFF;
    endtask

    initial begin
        resetn = 1'b0;
        clear_instr();
        cp0_status_ie = 1'b0; cp0_status_exl = 1'b0;
        cp0_epc = 32'd0; mem_busy = 1'b0; redirect_ready = 1'b1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_exc_we", cp0_exc_we, 0);
        resetn = 1'b1;
        tick();

        // 1: Ov in delay slot, memory idle
        mem_valid = 1'b1; mem_excepttype[bit_ov] = 1'b1;
        mem_pc = 32'h8000_0104; mem_in_delay = 1'b1;
        chk("t1_trig_flush", flush, 0);
        tick(); clear_instr();
        chk("t1_flush_c1", flush, 1);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_flush_c2", flush, 1);
        tick();
        chk("t1_flush_done", flush, 0);
        chk("t1_exc_we", cp0_exc_we, 1);
        chk("t1_exccode", cp0_exccode, 12);
        chk("t1_bd", cp0_bd, 1);
        chk("t1_epc", cp0_epc_o, 32'h8000_0100);
        chk("t1_bva_we", cp0_badvaddr_we, 0);
        tick();
        chk("t1_rv", redirect_valid, 1);
        chk("t1_rpc", redirect_pc, 32'hBFC0_0380);
        chk("t1_exc_we_off", cp0_exc_we, 0);
        tick();
        chk("t1_idle", busy, 0);
        chk("t1_rv_off", redirect_valid, 0);

        // 2: Tr + Sys together -> Tr, one strobe
        mem_valid = 1'b1; mem_excepttype[bit_tr] = 1'b1; mem_excepttype[bit_sys] = 1'b1;
        mem_pc = 32'h8000_0200;
        pulses = 0;
        tick(); clear_instr();
        for (int i = 0; i < 7; i++) begin
            if (cp0_exc_we) begin
                pulses++;
                chk("t2_exccode", cp0_exccode, 13);
                chk("t2_bd", cp0_bd, 0);
                chk("t2_epc", cp0_epc_o, 32'h8000_0200);
            end
            tick();
        end
        chk("t2_pulses", pulses, 1);
        chk("t2_idle", busy, 0);

        // 3: AdES with memory busy for 5 cycles from the trigger
        mem_valid = 1'b1; mem_excepttype[bit_ades] = 1'b1;
        mem_badvaddr = 32'h0000_0003; mem_busy = 1'b1;
        tick(); clear_instr();
        tick();
        tick();
        chk("t3_drain_flush", flush, 0);
        chk("t3_drain_busy", busy, 1);
        chk("t3_drain_we_a", cp0_exc_we, 0);
        tick();
        chk("t3_drain_we_b", cp0_exc_we, 0);
        tick(); mem_busy = 1'b0;
        chk("t3_drain_we_c", cp0_exc_we, 0);
        tick();
        chk("t3_exc_we", cp0_exc_we, 1);
        chk("t3_bva_we", cp0_badvaddr_we, 1);
        chk("t3_bva", cp0_badvaddr, 32'h0000_0003);
        chk("t3_exccode", cp0_exccode, 5);
        tick();
        chk("t3_rv", redirect_valid, 1);
        tick();
        chk("t3_idle", busy, 0);

        // 4: ERET, fetch stalls the redirect for 3 cycles
        mem_valid = 1'b1; mem_eret = 1'b1; cp0_epc = 32'h8000_2000; redirect_ready = 1'b0;
        tick(); clear_instr();
        tick();
        tick();
        chk("t4_exl_clr", cp0_exl_clr, 1);
        chk("t4_exc_we", cp0_exc_we, 0);
        tick();
        cp0_epc = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) redirect_ready = 1'b1;
            chk("t4_rv", redirect_valid, 1);
            chk("t4_rpc", redirect_pc, 32'h8000_2000);
            chk("t4_exl_clr_off", cp0_exl_clr, 0);
            tick();
        end
        chk("t4_idle", busy, 0);
        chk("t4_rv_off", redirect_valid, 0);

        // 5: interrupt gated by IE, then taken
        mem_valid = 1'b1; int_pending = 1'b1; cp0_status_ie = 1'b0;
        tick();
        chk("t5_masked_a", busy, 0);
        tick();
        chk("t5_masked_b", busy, 0);
        cp0_status_ie = 1'b1;
        tick(); clear_instr();
        chk("t5_taken", flush, 1);
        tick();
        tick();
        chk("t5_exc_we", cp0_exc_we, 1);
        chk("t5_exccode", cp0_exccode, 0);
        tick();
        tick();
        chk("t5_idle", busy, 0);

        // 5b: exception with EXL already set: redirect only, no CP0 write
        cp0_status_exl = 1'b1;
        mem_valid = 1'b1; mem_excepttype[bit_ri] = 1'b1; mem_pc = 32'h8000_0300;
        tick(); clear_instr(); cp0_status_exl = 1'b0;
        tick();
        tick();
        chk("t5b_exc_we", cp0_exc_we, 0);
        chk("t5b_exccode", cp0_exccode, 10);
        tick();
        chk("t5b_rv", redirect_valid, 1);
        chk("t5b_rpc", redirect_pc, 32'hBFC0_0380);
        tick();

        // 6: reset while in DRAIN
        mem_valid = 1'b1; mem_excepttype[bit_bp] = 1'b1; mem_pc = 32'h0000_1234; mem_busy = 1'b1;
        tick(); clear_instr();
        tick();
        tick();
        chk("t6_in_drain", busy, 1);
        resetn = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_exccode", cp0_exccode, 0);
        chk("t6_rst_epc", cp0_epc_o, 0);
        chk("t6_rst_rpc", redirect_pc, 0);
        tick();
        resetn = 1'b1; mem_busy = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cp0_exc_we || busy) pulses++;
        end
        chk("t6_no_commit", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
